ram_init: RTL and testbench



---
 rtl/ram_pkg.sv | 17 +
 rtl/ram_init_sync_bit.sv | 33 +++
 rtl/ram_init.sv | 129 ++++++++++++
 tb/tb_ram_init.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM bring-up path (reset generator and init sequencer).
// Latency: none; declarations only.
// Backpressure: not applicable.
package ram_pkg;

    // Bring-up sequencer states; encoding is fixed because it appears in debug captures.
    typedef enum logic [1:0] {
        WAIT_CAL = 2'd0,
        SETTLE   = 2'd1,
        FILL     = 2'd2,
        DONE     = 2'd3
    } ram_state_t;

    // Depth of every single-bit clock-domain synchronizer on the RAM path.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/ram_init_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// Latency: STAGES clk edges from d to q.
// Backpressure: none; level signal only.
//
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset; all stages clear to 0
//   d     - asynchronous input level
//   q     - synchronized output level
module sync_bit
    import ram_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ram_init.sv
// Memory bring-up sequencer: waits for calibration, settles, optionally zero-fills, then raises ram_ready.
// Latency: ram_ready 3+SETTLE_CYCLES+INIT_WORDS edges after calib_done rises (wr_ready held high).
// Backpressure: fill stalls with stable wr_addr/wr_data while wr_ready is low; calibration loss withdraws wr_valid.
//
// Ports:
//   clk_ui, aresetn_ui       - UI clock, asynchronous active-low reset
//   calib_done               - controller calibration flag (asynchronous, synchronized here)
//   fill_en                  - quasi-static, sampled when the settle interval ends
//   wr_valid/wr_ready        - fill write handshake; wr_addr word address, wr_data = FILL_PATTERN
//   ram_ready                - memory usable by clients
//   init_busy                - settling or filling
//   calib_lost               - sticky: calibration dropped after ram_ready; cleared only by reset
module ram_init
    import ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 24,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    INIT_WORDS    = 16384,
    parameter int                    SETTLE_CYCLES = 256,
    parameter logic [DATA_WIDTH-1:0] FILL_PATTERN  = '0
) (
    input  logic                  clk_ui,
    input  logic                  aresetn_ui,
    input  logic                  calib_done,
    input  logic                  fill_en,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  ram_ready,
    output logic                  init_busy,
    output logic                  calib_lost
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    // One extra address bit so a fill of the full 2^ADDR_WIDTH space terminates before wrapping.
    localparam logic [AW1-1:0]   LAST_ADDR    = AW1'(INIT_WORDS - 1);
    localparam bit               FILL_ALLOWED = (INIT_WORDS != 0);

    logic             cal_s;
    ram_state_t       state;
    ram_state_t       state_nxt;
    logic [CNT_W-1:0] settle_cnt;
    logic [AW1-1:0]   addr_q;
    logic             accept;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_cal_sync (
        .clk   (clk_ui),
        .rst_n (aresetn_ui),
        .d     (calib_done),
        .q     (cal_s)
    );

    assign accept = wr_valid & wr_ready;

    always_ff @(posedge clk_ui or negedge aresetn_ui) begin
        if (!aresetn_ui) begin
            state <= WAIT_CAL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state != WAIT_CAL && !cal_s) begin
            // Recalibration overrides everything, including an in-flight fill beat.
            state_nxt = WAIT_CAL;
        end else begin
            case (state)
                WAIT_CAL: if (cal_s) state_nxt = SETTLE;
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nxt = (fill_en && FILL_ALLOWED) ? FILL : DONE;
                    end
                end
                FILL:     if (accept && addr_q == LAST_ADDR) state_nxt = DONE;
                DONE:     state_nxt = DONE;
                default:  state_nxt = WAIT_CAL;
            endcase
        end
    end

    // Counter sits at 0 outside SETTLE, so SETTLE always starts counting from 0.
    always_ff @(posedge clk_ui or negedge aresetn_ui) begin
        if (!aresetn_ui) begin
            settle_cnt <= '0;
        end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else begin
            settle_cnt <= '0;
        end
    end

    always_ff @(posedge clk_ui or negedge aresetn_ui) begin
        if (!aresetn_ui) begin
            addr_q <= '0;
        end else if (state_nxt == WAIT_CAL) begin
            addr_q <= '0;
        end else if (state == SETTLE && state_nxt == FILL) begin
            addr_q <= '0;
        end else if (state == FILL && accept) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    // Output flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_ui or negedge aresetn_ui) begin
        if (!aresetn_ui) begin
            wr_valid   <= 1'b0;
            ram_ready  <= 1'b0;
            init_busy  <= 1'b0;
            calib_lost <= 1'b0;
        end else begin
            wr_valid   <= (state_nxt == FILL);
            ram_ready  <= (state_nxt == DONE);
            init_busy  <= (state_nxt == SETTLE) || (state_nxt == FILL);
            calib_lost <= calib_lost || (state == DONE && state_nxt == WAIT_CAL);
        end
    end

    assign wr_addr = addr_q[ADDR_WIDTH-1:0];
    assign wr_data = FILL_PATTERN;

endmodule

// File: tb/tb_ram_init.sv
module tb_ram_init;

    localparam int              AW  = 24;
    localparam int              DW  = 32;
    localparam int              IW  = 4;
    localparam int              SC  = 3;
    localparam logic [DW-1:0]   PAT = 32'hA5A5A5A5;

    logic          clk_ui     = 1'b0;
    logic          aresetn_ui = 1'b0;
    logic          calib_done = 1'b0;
    logic          fill_en    = 1'b1;
    logic          wr_ready   = 1'b1;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          ram_ready;
    logic          init_busy;
    logic          calib_lost;

    int checks = 0;
    int errors = 0;

    always #5 clk_ui = ~clk_ui;

    ram_init #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .INIT_WORDS    (IW),
        .SETTLE_CYCLES (SC),
        .FILL_PATTERN  (PAT)
    ) dut (
        .clk_ui     (clk_ui),
        .aresetn_ui (aresetn_ui),
        .calib_done (calib_done),
        .fill_en    (fill_en),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ram_ready  (ram_ready),
        .init_busy  (init_busy),
        .calib_lost (calib_lost)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: run = consecutive edges with synchronized calibration high,
    // words = fill beats accepted in the current pass.
    int m_run   = 0;
    int m_words = 0;
    bit m_fill  = 0;
    bit m_lost  = 0;
    bit m_c1    = 0;
    bit m_c2    = 0;
    bit m_cs    = 0;
    bit m_acc   = 0;
    bit e_valid = 0;
    bit e_ready = 0;
    bit e_busy  = 0;

    initial begin
        forever begin
            @(posedge clk_ui or negedge aresetn_ui);
            if (!aresetn_ui) begin
                m_run = 0; m_words = 0; m_fill = 0; m_lost = 0;
                m_c1 = 0; m_c2 = 0;
                e_valid = 0; e_ready = 0; e_busy = 0;
            end else begin
                m_cs  = m_c2;
                m_acc = e_valid && wr_ready;
                if (e_ready && !m_cs) m_lost = 1;
                if (!m_cs) begin
                    m_run = 0; m_words = 0; m_fill = 0;
                end else if (m_run <= SC) begin
                    m_run++;
                    if (m_run == SC + 1) begin
                        m_fill  = fill_en && (IW != 0);
                        m_words = 0;
                    end
                end else if (m_acc) begin
                    m_words++;
                end
                m_c2 = m_c1;
                m_c1 = calib_done;
                e_valid = (m_run == SC + 1) && m_fill && (m_words < IW);
                e_ready = (m_run == SC + 1) && !e_valid;
                e_busy  = (m_run >= 1 && m_run <= SC) || e_valid;
            end
        end
    end

    // Accept log: address and edge index of every handshake.
    logic [AW-1:0] acc_q[$];
    int            acc_cyc[$];
    int            cyc = 0;
    initial begin
        forever begin
            @(posedge clk_ui);
            cyc++;
            if (aresetn_ui && wr_valid && wr_ready) begin
                acc_q.push_back(wr_addr);
                acc_cyc.push_back(cyc);
            end
        end
    end

    // Per-cycle compare against the model, plus a running count of valid cycles.
    int vld_cycles = 0;
    initial begin
        forever begin
            @(negedge clk_ui);
            chk("valid", wr_valid, e_valid);
            chk("ready", ram_ready, e_ready);
            chk("busy", init_busy, e_busy);
            chk("lost", calib_lost, m_lost);
            chk("data", wr_data, PAT);
            if (e_valid) chk("addr", wr_addr, m_words);
            if (wr_valid) vld_cycles++;
        end
    end

    task automatic step();
        @(posedge clk_ui);
        #1;
    endtask

    task automatic wait_ready(input string name, input int exp_edges);
        int n = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (ram_ready) begin
                n = i;
                break;
            end
        end
        chk(name, n, exp_edges);
    endtask

    // Checks that the accepts logged since index base are exactly 0..IW-1 on consecutive edges.
    task automatic chk_accepts(input string name, input int base, input bit back_to_back);
        chk({name, "_count"}, acc_q.size() - base, IW);
        for (int i = 0; i < IW && base + i < acc_q.size(); i++) begin
            chk({name, "_addr"}, acc_q[base + i], i);
            if (back_to_back) chk({name, "_cyc"}, acc_cyc[base + i] - acc_cyc[base], i);
        end
    endtask

    task automatic pulse_reset();
        aresetn_ui = 1'b0;
        step();
        step();
        aresetn_ui = 1'b1;
        step();
    endtask

    initial begin
        int base;
        int vbase;
        bit found;

        // Reset values before any clock edge.
        #2;
        chk("rst_valid", wr_valid, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_ready", ram_ready, 0);
        chk("rst_busy", init_busy, 0);
        chk("rst_lost", calib_lost, 0);
        chk("rst_data", wr_data, PAT);
        step();
        aresetn_ui = 1'b1;
        step();
        step();

        // Normal fill: ready 3+3+4 edges after calibration.
        base = acc_q.size();
        calib_done = 1'b1;
        wait_ready("s1_ready_edges", 10);
        chk_accepts("s1", base, 1'b1);

        // Calibration lost in DONE: ready still high after 2 edges, low with lost set after 3.
        step();
        calib_done = 1'b0;
        step();
        step();
        chk("s5_ready_hold", ram_ready, 1);
        step();
        chk("s5_ready_drop", ram_ready, 0);
        chk("s5_lost_set", calib_lost, 1);
        step();

        // Recalibration with a 5-cycle stall on address 2.
        base = acc_q.size();
        calib_done = 1'b1;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (wr_valid && wr_addr == 2) begin
                found = 1;
                break;
            end
        end
        chk("s2_reach_addr2", found, 1);
        wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s2_stall_addr", wr_addr, 2);
            chk("s2_stall_valid", wr_valid, 1);
        end
        wr_ready = 1'b1;
        wait_ready("s2_ready_after_stall", 2);
        chk_accepts("s2", base, 1'b0);
        chk("s2_lost_sticky", calib_lost, 1);

        // No fill: ready 3+3 edges after calibration, never a write.
        calib_done = 1'b0;
        fill_en    = 1'b0;
        pulse_reset();
        base  = acc_q.size();
        vbase = vld_cycles;
        calib_done = 1'b1;
        wait_ready("s3_ready_edges", 6);
        step();
        chk("s3_no_accepts", acc_q.size() - base, 0);
        chk("s3_no_valid", vld_cycles - vbase, 0);
        chk("s3_lost_clear", calib_lost, 0);

        // Calibration drops after address 1 accepted, then the fill restarts at 0.
        calib_done = 1'b0;
        fill_en    = 1'b1;
        pulse_reset();
        base = acc_q.size();
        calib_done = 1'b1;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (acc_q.size() - base == 2) begin
                found = 1;
                break;
            end
        end
        chk("s4_two_accepts", found, 1);
        wr_ready   = 1'b0;
        calib_done = 1'b0;
        step();
        step();
        chk("s4_valid_hold", wr_valid, 1);
        step();
        chk("s4_valid_drop", wr_valid, 0);
        wr_ready = 1'b1;
        step();
        chk("s4_accepts_before", acc_q.size() - base, 2);
        base = acc_q.size();
        calib_done = 1'b1;
        wait_ready("s4_ready_edges", 10);
        chk_accepts("s4", base, 1'b1);
        chk("s4_lost_clear", calib_lost, 0);

        // Asynchronous reset mid-fill, then a complete repeat from address 0.
        pulse_reset();
        found = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (wr_valid && wr_addr == 1) begin
                found = 1;
                break;
            end
        end
        chk("s6_reach_fill", found, 1);
        #2;
        aresetn_ui = 1'b0;
        #1;
        chk("s6_async_valid", wr_valid, 0);
        chk("s6_async_addr", wr_addr, 0);
        chk("s6_async_busy", init_busy, 0);
        chk("s6_async_ready", ram_ready, 0);
        chk("s6_async_lost", calib_lost, 0);
        step();
        step();
        base = acc_q.size();
        aresetn_ui = 1'b1;
        wait_ready("s6_ready_edges", 10);
        chk_accepts("s6", base, 1'b1);

        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
